// File: rtl/frame_tx_streamer.sv
// frame_tx_streamer
//   Downstream stage of the frame assembler. Once a complete frame is available
//   it walks read_ptr through 0..FRAME_LEN-1, one address per SAMPLE_DIV clocks.
//   It presents each returned byte on dac_data for SAMPLE_DIV clocks, and then
//   pulses tx_done to release the assembler's buffers.
//
//   Optional feature macro: STREAMER_DC_BIAS_EN
//     defined   : frame_data is signed; dac_data = clamp(x + DC_BIAS, 0, 2**DATA_W-1),
//                 and the idle level is DC_BIAS.
//     undefined : dac_data = raw frame_data, and the idle level is 0.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : permits starting a new frame (level)
//   frame_full  : assembler output buffer holds a complete frame
//   frame_data  : assembler dout, valid 1 clk after read_ptr
//   read_ptr    : sample address into the assembled frame
//   tx_done     : 1-clk pulse once the last sample has been held for its full period
//   dac_data    : sample to the DAC, held for SAMPLE_DIV clks
//   dac_valid   : dac_data carries frame samples
//   busy        : FSM not in IDLE
//   frame_cnt   : completed frames, wrapping
module frame_tx_streamer #(
  parameter int FRAME_LEN  = 1120,
  parameter int PTR_W      = 11,
  parameter int DATA_W     = 8,
  parameter int SAMPLE_DIV = 4,
  parameter int GAP_CYCLES = 16,
  parameter int DC_BIAS    = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              frame_full,
  input  logic [DATA_W-1:0] frame_data,
  output logic [PTR_W-1:0]  read_ptr,
  output logic              tx_done,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic              busy,
  output logic [15:0]       frame_cnt
);
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int GAP_W = $clog2(GAP_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FRAME_LEN - 1);

  // Elaboration-time parameter sanity. SAMPLE_DIV >= 2 guarantees that the
  // registered frame_data has caught up with read_ptr by the capture edge.
  if (SAMPLE_DIV < 2 || GAP_CYCLES < 2 || (2 ** PTR_W) < FRAME_LEN ||
      DC_BIAS < 0 || DC_BIAS > (2 ** DATA_W) - 1) begin : g_bad_param
    $error("frame_tx_streamer: illegal parameter set");
  end

`ifdef STREAMER_DC_BIAS_EN
  localparam logic [DATA_W-1:0] IDLE_LVL = DATA_W'(DC_BIAS);

  // Signed sample plus bias, computed two bits wider so that both the
  // negative underflow and the positive overflow are visible before clamping.
  function automatic logic [DATA_W-1:0] shape(input logic [DATA_W-1:0] x);
    logic signed [DATA_W+1:0] sum;
    sum = $signed({{2{x[DATA_W-1]}}, x}) + $signed((DATA_W+2)'(DC_BIAS));
    if (sum < 0)
      return '0;
    else if (sum > $signed((DATA_W+2)'((2 ** DATA_W) - 1)))
      return '1;
    else
      return sum[DATA_W-1:0];
  endfunction
`else
  localparam logic [DATA_W-1:0] IDLE_LVL = '0;

  function automatic logic [DATA_W-1:0] shape(input logic [DATA_W-1:0] x);
    return x;
  endfunction
`endif

  typedef enum logic [1:0] {IDLE, STREAM, LAST, GAP} state_t;

  state_t            state, state_n;
  logic [DIV_W-1:0]  div_cnt, div_n;
  logic [GAP_W-1:0]  gap_cnt, gap_n;
  logic [PTR_W-1:0]  ptr_n;
  logic [DATA_W-1:0] data_n;
  logic              valid_n, done_n;
  logic [15:0]       cnt_n;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      gap_cnt   <= '0;
      read_ptr  <= '0;
      dac_data  <= IDLE_LVL;
      dac_valid <= 1'b0;
      tx_done   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      div_cnt   <= div_n;
      gap_cnt   <= gap_n;
      read_ptr  <= ptr_n;
      dac_data  <= data_n;
      dac_valid <= valid_n;
      tx_done   <= done_n;
      frame_cnt <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    gap_n   = gap_cnt;
    ptr_n   = read_ptr;
    data_n  = dac_data;
    valid_n = dac_valid;
    done_n  = 1'b0;
    cnt_n   = frame_cnt;
    case (state)
      IDLE: begin
        if (en && frame_full) begin
          state_n = STREAM;
          ptr_n   = '0;
          div_n   = '0;
        end
      end
      STREAM: begin
        // frame_full and en are deliberately ignored: a started frame always completes.
        if (div_cnt == DIV_LAST) begin
          div_n   = '0;
          data_n  = shape(frame_data);
          valid_n = 1'b1;
          if (read_ptr == PTR_LAST) begin
            ptr_n   = '0;
            state_n = LAST;
          end else begin
            ptr_n = read_ptr + PTR_W'(1);
          end
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      LAST: begin
        // The final sample gets its full SAMPLE_DIV hold before the pulse.
        if (div_cnt == DIV_LAST) begin
          div_n   = '0;
          gap_n   = '0;
          valid_n = 1'b0;
          data_n  = IDLE_LVL;
          done_n  = 1'b1;
          cnt_n   = frame_cnt + 16'd1;
          state_n = GAP;
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      GAP: begin
        // frame_full is still stale just after tx_done, so it is not looked at here.
        if (gap_cnt == GAP_LAST) begin
          gap_n   = '0;
          state_n = IDLE;
        end else begin
          gap_n = gap_cnt + GAP_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
